// File: rtl/pll_clk_manager.sv
// pll_clk_manager: lock qualification, system reset release and programmable clock enables (optional PLL_CLK_MGR_LOSS_CNT_EN adds loss_cnt)
module pll_clk_manager #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              align,
  output logic              sys_rst_n,
  output logic              locked,
  output logic              lock_lost,
`ifdef PLL_CLK_MGR_LOSS_CNT_EN
  output logic [NUM_CH-1:0] ce,
  output logic [7:0]        loss_cnt
`else
  output logic [NUM_CH-1:0] ce
`endif
);
  localparam int SW = $clog2(LOCK_STABLE);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [SW-1:0] stab_cnt;
  logic lock_s, run, align_q;
  assign lock_s = sync[SYNC_STAGES-1];
  assign run = state == RUN;
  // lock synchroniser
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pll_lock};
  // lock qualification: lock_s must hold for LOCK_STABLE consecutive cycles, counting the cycle it is first seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_LOCK;
      stab_cnt <= '0;
      sys_rst_n <= 1'b0;
      locked <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= run && !lock_s;
      case (state)
        WAIT_LOCK: begin
          stab_cnt <= '0;
          if (lock_s) state <= STABLE;
        end
        STABLE:
          if (!lock_s) begin
            state <= WAIT_LOCK;
            stab_cnt <= '0;
          end else if (stab_cnt == SW'(LOCK_STABLE - 2)) begin
            state <= RUN;
            sys_rst_n <= 1'b1;
            locked <= 1'b1;
          end else stab_cnt <= stab_cnt + 1'b1;
        RUN:
          if (!lock_s) begin
            state <= WAIT_LOCK;
            sys_rst_n <= 1'b0;
            locked <= 1'b0;
          end
        default: state <= WAIT_LOCK;
      endcase
    end
  // remembers an accepted align so the restart cycle emits no strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) align_q <= 1'b0;
    else align_q <= run && align;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] shadow, active, cnt, sh_nx, eff;
    logic wrap;
    assign sh_nx = (cfg_we && cfg_ch == CH_W'(i)) ? cfg_div : shadow;
    assign eff = active == '0 ? DIV_W'(1) : active;
    assign wrap = cnt == eff - 1'b1;
    assign ce[i] = run && wrap && !align_q;
    // shadow/active divider pair; active only changes at a period boundary so no period is cut short or stretched
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        shadow <= DIV_W'(DEFAULT_DIV);
        active <= DIV_W'(DEFAULT_DIV);
        cnt <= '0;
      end else begin
        shadow <= sh_nx;
        if (!run || align || wrap) active <= sh_nx;
        cnt <= (!run || !lock_s || align || wrap) ? '0 : cnt + 1'b1;
      end
  end
`ifdef PLL_CLK_MGR_LOSS_CNT_EN
  // saturating count of lock-loss events
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) loss_cnt <= '0;
    else if (lock_lost && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 1'b1;
`endif
endmodule
